otter_pipe_seq: RTL and testbench

Parametrised pipeline sequencer for the pipelined OTTER core. It replaces the fixed, always-enabled stage registers with a DEPTH-deep chain of stage records (EX, MEM, WB, ...), each with a valid bit. The chain supports global hold, branch flush, load-use bubble insertion and forwarding-source selection. It sits between the decoder and the datapath; the datapath reads stage payloads and forwarding selects from it.

---
 rtl/otter_pipe_seq.sv | 139 +++++++++++++
 tb/tb_otter_pipe_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/otter_pipe_seq.sv
// Pipeline sequencer for the pipelined OTTER core: DEPTH stage records with valid bits,
// hold, flush, load-use bubbles and forwarding selects. Optional counters: PIPE_PERF_CNT_EN.
module otter_pipe_seq #(
  parameter int PAYLOAD_W = 64,
  parameter int DEPTH     = 3,
  parameter int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       hold,
  input  logic                       flush,
  input  logic                       dec_valid,
  input  logic [PAYLOAD_W-1:0]       dec_payload,
  input  logic [4:0]                 dec_rs1,
  input  logic [4:0]                 dec_rs2,
  input  logic                       dec_rs1_used,
  input  logic                       dec_rs2_used,
  input  logic [4:0]                 dec_rd,
  input  logic                       dec_rd_used,
  input  logic                       dec_is_load,
  output logic                       dec_ready,
  output logic [DEPTH-1:0]           stg_valid,
  output logic [DEPTH*PAYLOAD_W-1:0] stg_payload,
  output logic [SEL_W-1:0]           fwd_a_sel,
  output logic [SEL_W-1:0]           fwd_b_sel,
  output logic                       retired
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]                perf_retired,
  output logic [31:0]                perf_stall,
  output logic [31:0]                perf_flush
`endif
);

  logic [DEPTH-1:0]                valid_r;
  logic [DEPTH-1:0][PAYLOAD_W-1:0] payload_r;
  logic [DEPTH-1:0][4:0]           rd_r;
  logic [DEPTH-1:0]                rd_used_r;
  logic [DEPTH-1:0]                is_load_r;
  logic                            stall_s;
  logic                            advance_s;
  logic                            bubble_s;

  // The youngest matching writer wins, so scan from the oldest stage down to stage 0.
  function automatic logic [SEL_W-1:0] fwd_sel(
    input logic [4:0]            rs,
    input logic                  rs_used,
    input logic [DEPTH-1:0]      v,
    input logic [DEPTH-1:0][4:0] rd,
    input logic [DEPTH-1:0]      rdu
  );
    logic [SEL_W-1:0] sel;
    sel = {SEL_W{1'b0}};
    if (rs_used && (rs != 5'd0)) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (v[k] && rdu[k] && (rd[k] == rs)) begin
          sel = SEL_W'(k + 1);
        end
      end
    end
    return sel;
  endfunction

  assign stg_valid   = valid_r;
  assign stg_payload = payload_r;

  // Hazard detection, handshake and forwarding selects.
  always_comb begin
    stall_s   = dec_valid & valid_r[0] & is_load_r[0] & rd_used_r[0] & (rd_r[0] != 5'd0) &
                (((rd_r[0] == dec_rs1) & dec_rs1_used) | ((rd_r[0] == dec_rs2) & dec_rs2_used));
    advance_s = ~RST & ~hold;
    bubble_s  = flush | stall_s;
    dec_ready = advance_s & (flush | ~stall_s);
    retired   = advance_s & valid_r[DEPTH-1];
    if (RST) begin
      fwd_a_sel = {SEL_W{1'b0}};
      fwd_b_sel = {SEL_W{1'b0}};
    end else begin
      fwd_a_sel = fwd_sel(dec_rs1, dec_rs1_used, valid_r, rd_r, rd_used_r);
      fwd_b_sel = fwd_sel(dec_rs2, dec_rs2_used, valid_r, rd_r, rd_used_r);
    end
  end

  // Stage chain; a bubble keeps its stale payload and only drops the valid bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_r   <= {DEPTH{1'b0}};
      payload_r <= '0;
      rd_r      <= '0;
      rd_used_r <= {DEPTH{1'b0}};
      is_load_r <= {DEPTH{1'b0}};
    end else if (!hold) begin
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i]   <= valid_r[i-1];
        payload_r[i] <= payload_r[i-1];
        rd_r[i]      <= rd_r[i-1];
        rd_used_r[i] <= rd_used_r[i-1];
        is_load_r[i] <= is_load_r[i-1];
      end
      if (bubble_s) begin
        valid_r[0] <= 1'b0;
      end else begin
        valid_r[0]   <= dec_valid;
        payload_r[0] <= dec_payload;
        rd_r[0]      <= dec_rd;
        rd_used_r[0] <= dec_rd_used;
        is_load_r[0] <= dec_is_load;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_retired_r;
  logic [31:0] perf_stall_r;
  logic [31:0] perf_flush_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
    return (en && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
  endfunction

  // Saturating event counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_retired_r <= 32'd0;
      perf_stall_r   <= 32'd0;
      perf_flush_r   <= 32'd0;
    end else begin
      perf_retired_r <= sat_inc(perf_retired_r, retired);
      perf_stall_r   <= sat_inc(perf_stall_r, advance_s & ~flush & stall_s);
      perf_flush_r   <= sat_inc(perf_flush_r, advance_s & flush);
    end
  end

  assign perf_retired = perf_retired_r;
  assign perf_stall   = perf_stall_r;
  assign perf_flush   = perf_flush_r;
`endif

endmodule

// File: tb/tb_otter_pipe_seq.sv
// Randomized scoreboard bench for otter_pipe_seq: a queue-based pipeline model predicts
// per-cycle outputs and the retirement order; a monitor compares on the falling edge.
module tb_otter_pipe_seq;
  localparam int PW    = 32;
  localparam int DEPTH = 3;
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic                  CLK, RST, hold, flush, dec_valid;
  logic [PW-1:0]         dec_payload;
  logic [4:0]            dec_rs1, dec_rs2, dec_rd;
  logic                  dec_rs1_used, dec_rs2_used, dec_rd_used, dec_is_load;
  logic                  dec_ready, retired;
  logic [DEPTH-1:0]      stg_valid;
  logic [DEPTH*PW-1:0]   stg_payload;
  logic [SEL_W-1:0]      fwd_a_sel, fwd_b_sel;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]           perf_retired, perf_stall, perf_flush;
`endif

  otter_pipe_seq #(.PAYLOAD_W(PW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .hold(hold), .flush(flush),
    .dec_valid(dec_valid), .dec_payload(dec_payload),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_rd_used(dec_rd_used), .dec_is_load(dec_is_load),
    .dec_ready(dec_ready), .stg_valid(stg_valid), .stg_payload(stg_payload),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .retired(retired)
`ifdef PIPE_PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  typedef struct {
    bit rst, hold, flush, dv;
    logic [PW-1:0] pl;
    bit [4:0] rs1, rs2, rd;
    bit u1, u2, rdu, ld;
  } stim_t;

  typedef struct {
    bit v;
    logic [PW-1:0] p;
    bit [4:0] rd;
    bit rdu, ld;
  } rec_t;

  typedef struct {
    bit rdy, ret;
    bit [SEL_W-1:0] fa, fb;
    bit [DEPTH-1:0] v;
    logic [PW-1:0] p [DEPTH];
    bit [31:0] pr, ps, pf;
  } exp_t;

  rec_t          pipe [DEPTH];
  exp_t          expq [$];
  logic [PW-1:0] accq [$];
  bit [31:0]     m_pr, m_ps, m_pf;
  int            n_chk = 0;
  int            n_pass = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit [SEL_W-1:0] model_fwd(input bit [4:0] rs, input bit used);
    if (!used || rs == 5'd0) return '0;
    for (int k = 0; k < DEPTH; k++)
      if (pipe[k].v && pipe[k].rdu && pipe[k].rd == rs) return SEL_W'(k + 1);
    return '0;
  endfunction

  function automatic stim_t mk(input bit dv, input logic [PW-1:0] pl, input bit [4:0] rd,
                               input bit rdu, input bit ld, input bit [4:0] rs1, input bit u1,
                               input bit [4:0] rs2, input bit u2);
    stim_t s;
    s = '{rst: 1'b0, hold: 1'b0, flush: 1'b0, dv: dv, pl: pl, rs1: rs1, rs2: rs2, rd: rd,
          u1: u1, u2: u2, rdu: rdu, ld: ld};
    return s;
  endfunction

  function automatic bit [31:0] sat(input bit [31:0] c, input bit en);
    return (en && c != 32'hFFFF_FFFF) ? c + 32'd1 : c;
  endfunction

  // One clock: apply stimulus, predict this cycle's outputs, then advance the model.
  task automatic go(input stim_t s);
    exp_t e;
    rec_t nr;
    bit stall;
    @(posedge CLK); #1;
    RST = s.rst; hold = s.hold; flush = s.flush; dec_valid = s.dv; dec_payload = s.pl;
    dec_rs1 = s.rs1; dec_rs2 = s.rs2; dec_rs1_used = s.u1; dec_rs2_used = s.u2;
    dec_rd = s.rd; dec_rd_used = s.rdu; dec_is_load = s.ld;
    stall = s.dv && pipe[0].v && pipe[0].ld && pipe[0].rdu && pipe[0].rd != 5'd0 &&
            ((pipe[0].rd == s.rs1 && s.u1) || (pipe[0].rd == s.rs2 && s.u2));
    e.rdy = !s.rst && !s.hold && (s.flush || !stall);
    e.ret = !s.rst && !s.hold && pipe[DEPTH-1].v;
    e.fa  = s.rst ? '0 : model_fwd(s.rs1, s.u1);
    e.fb  = s.rst ? '0 : model_fwd(s.rs2, s.u2);
    for (int i = 0; i < DEPTH; i++) begin
      e.v[i] = pipe[i].v;
      e.p[i] = pipe[i].p;
    end
    e.pr = m_pr; e.ps = m_ps; e.pf = m_pf;
    expq.push_back(e);
    if (s.rst) begin
      foreach (pipe[i]) pipe[i].v = 1'b0;
      accq.delete();
      m_pr = 0; m_ps = 0; m_pf = 0;
    end else if (!s.hold) begin
      m_pr = sat(m_pr, e.ret);
      m_ps = sat(m_ps, !s.flush && stall);
      m_pf = sat(m_pf, s.flush);
      nr = '{v: 1'b0, p: '0, rd: 5'd0, rdu: 1'b0, ld: 1'b0};
      if (!s.flush && !stall) begin
        nr = '{v: s.dv, p: s.pl, rd: s.rd, rdu: s.rdu, ld: s.ld};
        if (s.dv) accq.push_back(s.pl);
      end
      for (int i = DEPTH - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = nr;
    end
  endtask

  // Monitor: pop one expectation per cycle; retirements are matched against accept order.
  always @(negedge CLK) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("dec_ready", 64'(dec_ready), 64'(e.rdy));
      chk("retired", 64'(retired), 64'(e.ret));
      chk("fwd_a_sel", 64'(fwd_a_sel), 64'(e.fa));
      chk("fwd_b_sel", 64'(fwd_b_sel), 64'(e.fb));
      chk("stg_valid", 64'(stg_valid), 64'(e.v));
      for (int i = 0; i < DEPTH; i++)
        if (e.v[i]) chk($sformatf("stg_payload%0d", i), 64'(stg_payload[i*PW +: PW]), 64'(e.p[i]));
`ifdef PIPE_PERF_CNT_EN
      chk("perf_retired", 64'(perf_retired), 64'(e.pr));
      chk("perf_stall", 64'(perf_stall), 64'(e.ps));
      chk("perf_flush", 64'(perf_flush), 64'(e.pf));
`endif
      if (retired) begin
        if (accq.size() == 0) chk("retire_order_empty", 64'(retired), 64'd0);
        else chk("retire_payload", 64'(stg_payload[(DEPTH-1)*PW +: PW]), 64'(accq.pop_front()));
      end
    end
  end

  initial begin
    stim_t s, idle;
    idle = mk(1'b0, '0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    RST = 1'b1; hold = 1'b0; flush = 1'b0; dec_valid = 1'b0; dec_payload = '0;
    dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rs1_used = 1'b0; dec_rs2_used = 1'b0;
    dec_rd = 5'd0; dec_rd_used = 1'b0; dec_is_load = 1'b0;
    foreach (pipe[i]) pipe[i] = '{v: 1'b0, p: '0, rd: 5'd0, rdu: 1'b0, ld: 1'b0};
    m_pr = 0; m_ps = 0; m_pf = 0;
    repeat (2) @(posedge CLK);
    s = idle; s.rst = 1'b1;
    repeat (2) go(s);

    for (int i = 1; i <= 5; i++) go(mk(1'b1, PW'(i), 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
    repeat (4) go(idle);

    // Load x5 then a dependent add: one stall, then forwarding from stage 1.
    go(mk(1'b1, 32'h10, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0));
    repeat (2) go(mk(1'b1, 32'h11, 5'd8, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0));
    repeat (3) go(idle);

    go(mk(1'b1, 32'h20, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
    go(mk(1'b1, 32'h21, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1));
    go(mk(1'b1, 32'h22, 5'd10, 1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1));
    go(mk(1'b1, 32'h23, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
    go(mk(1'b1, 32'h24, 5'd11, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0));
    repeat (3) go(idle);

    s = mk(1'b1, 32'hAA, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); s.flush = 1'b1;
    go(s);
    repeat (3) go(idle);

    // Full pipeline, 3-cycle hold with a flush raised inside it and held until release.
    for (int i = 0; i < 3; i++) go(mk(1'b1, PW'(32'h30 + i), 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
    s = mk(1'b1, 32'h40, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    s.hold = 1'b1; go(s);
    s.flush = 1'b1; go(s); go(s);
    s.hold = 1'b0; go(s);
    repeat (3) go(idle);

    for (int i = 0; i < 3; i++) go(mk(1'b1, PW'(32'h50 + i), 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0));
    s = idle; s.rst = 1'b1; go(s);
    go(idle);

    for (int n = 0; n < 3000; n++) begin
      s.rst   = ($urandom_range(99, 0) == 0);
      s.hold  = ($urandom_range(4, 0) == 0);
      s.flush = ($urandom_range(7, 0) == 0);
      s.dv    = ($urandom_range(3, 0) != 0);
      s.pl    = PW'($urandom);
      s.rs1   = 5'($urandom_range(3, 0));
      s.rs2   = 5'($urandom_range(3, 0));
      s.rd    = 5'($urandom_range(3, 0));
      s.u1    = ($urandom_range(3, 0) != 0);
      s.u2    = ($urandom_range(3, 0) != 0);
      s.rdu   = ($urandom_range(3, 0) != 0);
      s.ld    = ($urandom_range(2, 0) == 0);
      go(s);
    end
    repeat (2) go(idle);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
